bus_loader: RTL and testbench
=============================

Name: bus_loader

Overview:
- Byte-stream-driven initiator on the 32-bit dmem-style valid/ready bus. It is the master side of the bus that RAM and UART answer as responders.
- Takes command bytes from a UART receive stream, issues word reads and writes on the bus, and returns status and read data on a UART transmit stream.
- Used for program loading and debug poking of RAM while the CPU is held in reset.

Parameters:
- TIMEOUT, 1024, cycles bus_valid may stay high without bus_ready before the transaction is abandoned (>=2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_valid  in  1  command byte available.
- rx_ready  out  1  loader accepts rx_data this cycle.
- rx_data  in  8  command byte.
- tx_valid  out  1  response byte available.
- tx_ready  in  1  sink accepts tx_data this cycle.
- tx_data  out  8  response byte.
- bus_valid  out  1  bus request.
- bus_ready  in  1  responder completes request.
- bus_addr  out  32  byte address, passed unmodified.
- bus_wmask  out  4  4'hf for write, 4'h0 for read.
- bus_wdata  out  32  write data.
- bus_rdata  in  32  read data, valid one cycle after handshake.
- busy  out  1  high in any state other than OP.
- err  out  1  sticky error flag.

Behaviour:
- Reset (reset low, asynchronous): state=OP. rx_ready=1, tx_valid=0, tx_data=0, bus_valid=0, bus_addr=0, bus_wmask=0, bus_wdata=0, busy=0, err=0. Released synchronously on the next edge after reset goes high.
- Stream handshakes: a byte transfers on any edge where valid&&ready.
  - tx_data and tx_valid stay stable until accepted.
  - rx_ready=1 only in OP, ADDR and DATA.
- Bus handshake: the transfer completes on the edge where bus_valid&&bus_ready.
  - bus_addr, bus_wmask and bus_wdata stay stable while bus_valid=1.
  - bus_valid drops the cycle after completion.
  - bus_rdata is captured on the edge following completion, to match registered-output RAM.
- Commands; multi-byte fields are little-endian (LSB first):
  - 0x57 'W': 4 address bytes, then 4 data bytes. Bus write with wmask=4'hf. Response 0x4B 'K'.
  - 0x52 'R': 4 address bytes. Bus read with wmask=4'h0. Response 4 data bytes, LSB first.
  - Any other opcode: consumed, err set, response 0x3F '?', then back to OP.
- States:
  - OP: accept opcode, then go to ADDR; unknown opcode goes to RESP.
  - ADDR: 4 bytes, 2-bit counter.
    - W: to DATA.
    - R: to BUS.
  - DATA: 4 bytes, then to BUS.
  - BUS: bus_valid=1 with the timeout counter running.
    - On handshake, W goes to RESP ('K').
    - On handshake, R goes to RDLAT.
  - RDLAT: one cycle; capture bus_rdata into a shift register; go to RESP.
  - RESP: emit 1 byte (K/E/?) or 4 read-data bytes, shifting after each accept; then to OP.
- Timeout:
  - The counter resets on entry to BUS.
  - If it reaches TIMEOUT-1 with no bus_ready, bus_valid drops the next cycle, err is set, and the response is 0x45 'E'.
  - bus_ready arriving in the same cycle as the terminal count counts as a success.
- bus_ready high while bus_valid=0 is ignored.
- err is sticky until reset; it has no effect on command processing.
- Back-to-back commands: the next opcode is accepted in the cycle after the last response byte is accepted. No bytes are buffered while busy, because rx_ready=0.
- Reset mid-transaction: bus_valid and tx_valid drop immediately, and partial command bytes are discarded.

Test Plan:
- Write: rx stream 57 00 01 00 00 EF BE AD DE with bus_ready=1. Expect one bus cycle with addr=0x00000100, wmask=f, wdata=0xDEADBEEF, then tx 0x4B; err=0.
- Read: rx 52 00 01 00 00; responder returns 0x12345678 one cycle after handshake. Expect bus_wmask=0 and tx 78 56 34 12 in order.
- Backpressure: tx_ready held low 5 cycles during the read response. Expect tx_data stable and no byte lost; rx_ready=0 throughout.
- Wait states: bus_ready delayed 7 cycles. Expect addr, wdata and wmask stable for all 8 valid cycles and a single completion.
- Timeout: TIMEOUT=16 and bus_ready never high. Expect bus_valid high exactly 16 cycles, then tx 0x45 and err=1. A following valid 'R' still completes.
- Bad opcode plus reset: rx 0x00 gives tx 0x3F and err=1. Asserting reset low mid-ADDR clears err, busy and bus_valid asynchronously, and the next 'W' works.

Source files
------------

// File: rtl/bus_loader_if.sv
// UART-stream and dmem-bus signal bundle for the byte-driven bus loader.
// Latency: n/a (wires only).
// Backpressure: rx/tx use valid/ready; the bus uses valid/ready with a bounded wait.
// master: the loader itself. slave: the UART endpoints, bus responder and status observer.
interface bus_loader_if;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  rx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        bus_valid;
    logic        bus_ready;
    logic [31:0] bus_addr;
    logic [3:0]  bus_wmask;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        busy;
    logic        err;

    modport master (
        input  rx_valid, rx_data, tx_ready, bus_ready, bus_rdata,
        output rx_ready, tx_valid, tx_data, bus_valid, bus_addr, bus_wmask, bus_wdata,
               busy, err
    );

    modport slave (
        output rx_valid, rx_data, tx_ready, bus_ready, bus_rdata,
        input  rx_ready, tx_valid, tx_data, bus_valid, bus_addr, bus_wmask, bus_wdata,
               busy, err
    );
endinterface

// File: rtl/bus_loader.sv
// Byte-stream command interpreter driving word reads/writes on the dmem valid/ready bus.
// Latency: one cycle per rx byte, bus wait + 1 cycle (read adds RDLAT), then one cycle per tx byte.
// Backpressure: rx_ready only while collecting a command; tx held until accepted; bus abandoned after TIMEOUT cycles.
// Ports: clk, reset (async active-low), lb (rx stream in, tx stream out, bus master, busy/err status).
module bus_loader #(
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         reset,
    bus_loader_if.master lb
);
    localparam int             TW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]     OP_W     = 8'h57;
    localparam logic [7:0]     OP_R     = 8'h52;
    localparam logic [7:0]     RSP_K    = 8'h4B;
    localparam logic [7:0]     RSP_E    = 8'h45;
    localparam logic [7:0]     RSP_Q    = 8'h3F;

    typedef enum logic [2:0] {S_OP, S_ADDR, S_DATA, S_BUS, S_RDLAT, S_RESP} state_t;

    state_t         r_state;
    logic           r_is_wr;
    logic [1:0]     r_cnt;
    logic [1:0]     r_left;     // remaining response bytes after the one on tx_data
    logic [TW-1:0]  r_tmo;
    logic [31:0]    r_resp;
    logic           r_rx_ready;
    logic           r_tx_valid;
    logic [7:0]     r_tx_data;
    logic           r_bus_valid;
    logic [31:0]    r_addr;
    logic [3:0]     r_wmask;
    logic [31:0]    r_wdata;
    logic           r_busy;
    logic           r_err;

    logic w_rx_fire;
    logic w_tx_fire;

    assign w_rx_fire = lb.rx_valid && r_rx_ready;
    assign w_tx_fire = r_tx_valid && lb.tx_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_OP;
            r_is_wr     <= 1'b0;
            r_cnt       <= 2'd0;
            r_left      <= 2'd0;
            r_tmo       <= '0;
            r_resp      <= 32'd0;
            r_rx_ready  <= 1'b1;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= 8'd0;
            r_bus_valid <= 1'b0;
            r_addr      <= 32'd0;
            r_wmask     <= 4'h0;
            r_wdata     <= 32'd0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_OP: begin
                    if (w_rx_fire) begin
                        r_busy <= 1'b1;
                        r_cnt  <= 2'd0;
                        if (lb.rx_data == OP_W || lb.rx_data == OP_R) begin
                            r_is_wr <= (lb.rx_data == OP_W);
                            r_wmask <= (lb.rx_data == OP_W) ? 4'hf : 4'h0;
                            r_state <= S_ADDR;
                        end else begin
                            r_err      <= 1'b1;
                            r_rx_ready <= 1'b0;
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= RSP_Q;
                            r_left     <= 2'd0;
                            r_state    <= S_RESP;
                        end
                    end
                end
                S_ADDR: begin
                    if (w_rx_fire) begin
                        // LSB arrives first, so shift in from the top.
                        r_addr <= {lb.rx_data, r_addr[31:8]};
                        r_cnt  <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            if (r_is_wr) begin
                                r_state <= S_DATA;
                            end else begin
                                r_rx_ready  <= 1'b0;
                                r_bus_valid <= 1'b1;
                                r_tmo       <= '0;
                                r_state     <= S_BUS;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (w_rx_fire) begin
                        r_wdata <= {lb.rx_data, r_wdata[31:8]};
                        r_cnt   <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_rx_ready  <= 1'b0;
                            r_bus_valid <= 1'b1;
                            r_tmo       <= '0;
                            r_state     <= S_BUS;
                        end
                    end
                end
                S_BUS: begin
                    // Ready on the terminal-count cycle still wins over the timeout.
                    if (lb.bus_ready) begin
                        r_bus_valid <= 1'b0;
                        if (r_is_wr) begin
                            r_tx_valid <= 1'b1;
                            r_tx_data  <= RSP_K;
                            r_left     <= 2'd0;
                            r_state    <= S_RESP;
                        end else begin
                            r_state <= S_RDLAT;
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        r_bus_valid <= 1'b0;
                        r_err       <= 1'b1;
                        r_tx_valid  <= 1'b1;
                        r_tx_data   <= RSP_E;
                        r_left      <= 2'd0;
                        r_state     <= S_RESP;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                S_RDLAT: begin
                    // Responder presents read data one cycle after the handshake.
                    r_resp     <= lb.bus_rdata;
                    r_tx_data  <= lb.bus_rdata[7:0];
                    r_tx_valid <= 1'b1;
                    r_left     <= 2'd3;
                    r_state    <= S_RESP;
                end
                S_RESP: begin
                    if (w_tx_fire) begin
                        if (r_left == 2'd0) begin
                            r_tx_valid <= 1'b0;
                            r_rx_ready <= 1'b1;
                            r_busy     <= 1'b0;
                            r_state    <= S_OP;
                        end else begin
                            r_tx_data <= r_resp[15:8];
                            r_resp    <= {8'h00, r_resp[31:8]};
                            r_left    <= r_left - 2'd1;
                        end
                    end
                end
                default: begin
                    r_state    <= S_OP;
                    r_rx_ready <= 1'b1;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign lb.rx_ready  = r_rx_ready;
    assign lb.tx_valid  = r_tx_valid;
    assign lb.tx_data   = r_tx_data;
    assign lb.bus_valid = r_bus_valid;
    assign lb.bus_addr  = r_addr;
    assign lb.bus_wmask = r_wmask;
    assign lb.bus_wdata = r_wdata;
    assign lb.busy      = r_busy;
    assign lb.err       = r_err;
endmodule

// File: tb/tb_bus_loader.sv
// Self-checking bench for bus_loader: directed scenarios then randomized commands.
// Latency: n/a. Backpressure: bench stalls tx_ready and delays bus_ready on purpose.
module tb_bus_loader;
    localparam int TB_TIMEOUT = 16;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bus_loader_if lb();
    bus_loader #(.TIMEOUT(TB_TIMEOUT)) dut (.clk(clk), .reset(reset), .lb(lb));

    int tests = 0;
    int fails = 0;
    bit err_exp = 1'b0;

    // responder knobs
    int ready_delay = 0;
    bit never_ready = 1'b0;
    bit noise = 1'b0;

    // RAM seen by the responder, and the reference model of what reads should return
    logic [31:0] ram [logic [31:0]];
    logic [31:0] mdl [logic [31:0]];

    // transactions observed on the bus
    logic [31:0] q_addr [$];
    logic [3:0]  q_wmask [$];
    logic [31:0] q_wdata [$];
    bit          q_ok [$];
    int          q_cyc [$];
    bit          q_stable [$];

    function automatic logic [31:0] mem_init(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : mem_init(a);
    endfunction

    function automatic logic [31:0] mdl_rd(input logic [31:0] a);
        return mdl.exists(a) ? mdl[a] : mem_init(a);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Bus responder: decides bus_ready at each falling edge, detects handshakes/abandons.
    initial begin : responder
        bit          last_v;
        int          vcyc;
        logic [31:0] cap_addr;
        logic [3:0]  cap_wmask;
        logic [31:0] cap_wdata;
        bit          cap_stable;
        last_v = 0; vcyc = 0; cap_addr = 0; cap_wmask = 0; cap_wdata = 0; cap_stable = 1;
        lb.bus_ready = 1'b0;
        lb.bus_rdata = 32'd0;
        forever begin
            @(negedge clk);
            lb.bus_rdata = $urandom;
            if (!reset) begin
                last_v = 0; vcyc = 0; lb.bus_ready = 1'b0;
            end else begin
                if (last_v && lb.bus_ready) begin
                    q_addr.push_back(cap_addr); q_wmask.push_back(cap_wmask);
                    q_wdata.push_back(cap_wdata); q_ok.push_back(1'b1);
                    q_cyc.push_back(vcyc); q_stable.push_back(cap_stable);
                    if (cap_wmask == 4'hf) ram[cap_addr] = cap_wdata;
                    else lb.bus_rdata = ram_rd(cap_addr);
                    vcyc = 0;
                end else if (last_v && !lb.bus_valid) begin
                    q_addr.push_back(cap_addr); q_wmask.push_back(cap_wmask);
                    q_wdata.push_back(cap_wdata); q_ok.push_back(1'b0);
                    q_cyc.push_back(vcyc); q_stable.push_back(cap_stable);
                    vcyc = 0;
                end
                if (lb.bus_valid) begin
                    if (vcyc == 0) begin
                        cap_addr = lb.bus_addr; cap_wmask = lb.bus_wmask;
                        cap_wdata = lb.bus_wdata; cap_stable = 1;
                    end else if (lb.bus_addr !== cap_addr || lb.bus_wmask !== cap_wmask ||
                                 lb.bus_wdata !== cap_wdata) begin
                        cap_stable = 0;
                    end
                    vcyc++;
                    lb.bus_ready = !never_ready && (vcyc > ready_delay);
                end else begin
                    lb.bus_ready = noise ? 1'($urandom_range(0, 1)) : 1'b0;
                end
                last_v = lb.bus_valid;
            end
        end
    end

    task automatic clear_q();
        q_addr.delete(); q_wmask.delete(); q_wdata.delete();
        q_ok.delete(); q_cyc.delete(); q_stable.delete();
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send_byte(input logic [7:0] d);
        int n;
        n = 0;
        lb.rx_valid = 1'b1;
        lb.rx_data  = d;
        while (!lb.rx_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("rx_accept_timeout", 32'(n), 32'd0);
        @(negedge clk);
        lb.rx_valid = 1'b0;
    endtask

    task automatic recv_byte(output logic [7:0] d, input int stall);
        int n;
        n = 0;
        while (!lb.tx_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("tx_wait_timeout", 32'(n), 32'd0);
        d = lb.tx_data;
        chk("busy_in_resp", lb.busy, 1'b1);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            chk("tx_data_stable", lb.tx_data, d);
            chk("tx_valid_held", lb.tx_valid, 1'b1);
            chk("rx_ready_low_in_resp", lb.rx_ready, 1'b0);
        end
        lb.tx_ready = 1'b1;
        @(negedge clk);
        lb.tx_ready = 1'b0;
    endtask

    task automatic run_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] d,
                           input int delay, input bit nr, input int stall);
        logic [7:0]  exp_b [$];
        logic [7:0]  got;
        logic [31:0] rv;
        bit          is_cmd;
        is_cmd = (op == 8'h57 || op == 8'h52);
        ready_delay = delay;
        never_ready = nr;
        clear_q();
        send_byte(op);
        if (is_cmd) for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        if (op == 8'h57) for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
        if (!is_cmd) begin
            exp_b.push_back(8'h3F); err_exp = 1'b1;
        end else if (nr) begin
            exp_b.push_back(8'h45); err_exp = 1'b1;
        end else if (op == 8'h57) begin
            exp_b.push_back(8'h4B); mdl[a] = d;
        end else begin
            rv = mdl_rd(a);
            for (int i = 0; i < 4; i++) exp_b.push_back(rv[8*i +: 8]);
        end
        foreach (exp_b[i]) begin
            recv_byte(got, stall);
            chk($sformatf("resp_byte%0d_op%02h", i, op), got, exp_b[i]);
        end
        chk("rx_ready_after_resp", lb.rx_ready, 1'b1);
        chk("busy_after_resp", lb.busy, 1'b0);
        chk("err_after_cmd", lb.err, err_exp);
        if (!is_cmd) begin
            chk("bus_txn_count_bad_op", 32'(q_addr.size()), 32'd0);
        end else begin
            chk("bus_txn_count", 32'(q_addr.size()), 32'd1);
            if (q_addr.size() > 0) begin
                chk("bus_addr", q_addr[0], a);
                chk("bus_wmask", q_wmask[0], (op == 8'h57) ? 4'hf : 4'h0);
                if (op == 8'h57) chk("bus_wdata", q_wdata[0], d);
                chk("bus_completed", q_ok[0], !nr);
                chk("bus_valid_cycles", 32'(q_cyc[0]), nr ? 32'(TB_TIMEOUT) : 32'(delay + 1));
                chk("bus_fields_stable", q_stable[0], 1'b1);
            end
        end
    endtask

    // Asynchronous reset asserted mid-cycle, outputs checked before any clock edge.
    task automatic do_reset();
        #2 reset = 1'b0;
        lb.rx_valid = 1'b0;
        lb.tx_ready = 1'b0;
        #1;
        chk("rst_bus_valid", lb.bus_valid, 1'b0);
        chk("rst_tx_valid", lb.tx_valid, 1'b0);
        chk("rst_err", lb.err, 1'b0);
        chk("rst_busy", lb.busy, 1'b0);
        chk("rst_rx_ready", lb.rx_ready, 1'b1);
        err_exp = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        clear_q();
        @(negedge clk);
    endtask

    initial begin : main
        int n;
        reset = 1'b0;
        lb.rx_valid = 1'b0;
        lb.rx_data  = 8'd0;
        lb.tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rx_ready", lb.rx_ready, 1'b1);
        chk("reset_tx_valid", lb.tx_valid, 1'b0);
        chk("reset_tx_data", lb.tx_data, 8'd0);
        chk("reset_bus_valid", lb.bus_valid, 1'b0);
        chk("reset_bus_addr", lb.bus_addr, 32'd0);
        chk("reset_bus_wmask", lb.bus_wmask, 4'h0);
        chk("reset_bus_wdata", lb.bus_wdata, 32'd0);
        chk("reset_busy", lb.busy, 1'b0);
        chk("reset_err", lb.err, 1'b0);
        reset = 1'b1;
        @(negedge clk);

        // plain write, then read with a known RAM word and tx backpressure
        run_cmd(8'h57, 32'h0000_0100, 32'hDEAD_BEEF, 0, 1'b0, 0);
        ram[32'h100] = 32'h1234_5678;
        mdl[32'h100] = 32'h1234_5678;
        run_cmd(8'h52, 32'h0000_0100, 32'd0, 0, 1'b0, 5);

        // bus wait states
        run_cmd(8'h57, 32'h0000_2004, 32'hCAFE_F00D, 7, 1'b0, 0);
        run_cmd(8'h52, 32'h0000_2004, 32'd0, 3, 1'b0, 1);

        // boundary: ready arrives exactly on the terminal count
        run_cmd(8'h57, 32'h0000_2008, 32'h0BAD_CAFE, TB_TIMEOUT - 1, 1'b0, 0);

        // timeout, then a normal read still works with err left set
        run_cmd(8'h52, 32'h0000_0300, 32'd0, 0, 1'b1, 0);
        run_cmd(8'h52, 32'h0000_2004, 32'd0, 0, 1'b0, 0);

        // bad opcode after a reset
        do_reset();
        run_cmd(8'h00, 32'd0, 32'd0, 0, 1'b0, 0);

        // reset mid-ADDR, then a clean write and read-back
        send_byte(8'h57);
        send_byte(8'h00);
        send_byte(8'h01);
        do_reset();
        run_cmd(8'h57, 32'h0000_0400, 32'hA5A5_1234, 1, 1'b0, 0);
        run_cmd(8'h52, 32'h0000_0400, 32'd0, 0, 1'b0, 2);

        // reset while the bus request is outstanding
        never_ready = 1'b1;
        send_byte(8'h52);
        for (int i = 0; i < 4; i++) send_byte(8'h10);
        n = 0;
        while (!lb.bus_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("bus_valid_before_reset", lb.bus_valid, 1'b1);
        do_reset();
        never_ready = 1'b0;
        run_cmd(8'h57, 32'h0000_0500, 32'h0F0F_F0F0, 0, 1'b0, 0);

        // randomized command mix against the reference model
        noise = 1'b1;
        for (int it = 0; it < 30; it++) begin
            logic [7:0]  op;
            logic [31:0] a;
            int          sel;
            sel = $urandom_range(0, 9);
            a = {28'h0000_100, 2'($urandom_range(0, 3)), 2'b00};
            if (sel == 0) begin
                op = 8'($urandom_range(0, 255));
                while (op == 8'h57 || op == 8'h52) op = 8'($urandom_range(0, 255));
            end else begin
                op = (sel < 5) ? 8'h57 : 8'h52;
            end
            run_cmd(op, a, $urandom, $urandom_range(0, 5),
                    ($urandom_range(0, 9) == 0), $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, observed hang expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
